// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad: matrix geometry, key positions
// and the digit codes the encoder side also uses.
package keypad_pkg;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int KEYS     = ROWS * COLS;
    localparam int KEY_STAR = 9;
    localparam int KEY_HASH = 11;

    localparam logic [3:0] CODE_STAR = 4'd10;
    localparam logic [3:0] CODE_HASH = 4'd11;
    localparam logic [3:0] CODE_NONE = 4'd15;

    // One bit per matrix position, index row*COLS + col, 1 = key closed.
    typedef logic [KEYS-1:0] key_map_t;

    function automatic logic [3:0] key_to_digit(input int unsigned idx);
        logic [3:0] code;
        case (idx)
            0, 1, 2, 3, 4, 5, 6, 7, 8: code = 4'(idx + 1);
            9:                         code = CODE_STAR;
            10:                        code = 4'd0;
            11:                        code = CODE_HASH;
            default:                   code = CODE_NONE;
        endcase
        return code;
    endfunction

    function automatic int unsigned key_count(input key_map_t keys);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEYS; i++) begin
            n = n + 32'(keys[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones so
// pulled-up lines read as idle.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignment so both flops sample
    // their inputs from the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans the 4x3 front-panel matrix column by column, debounces whole scans and
// drives level-coded digit, start and clear outputs plus a press strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [9:0]      keypad,
    output logic            startn,
    output logic            clearn,
    output logic            press_strobe
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [ROWS-1:0] row_sync;
    logic [DW-1:0]   dwell;
    logic [1:0]      col;
    logic [1:0]      col_next;
    key_map_t        snapshot;
    key_map_t        snap_next;
    key_map_t        candidate;
    key_map_t        committed;
    key_map_t        commit_value;
    logic [SW-1:0]   stable;
    logic [SW-1:0]   stable_next;
    logic            commit_pulse;
    logic            sample;
    logic            scan_end;
    logic            commit;
    logic [9:0]      keypad_next;

    sync2 #(.WIDTH(ROWS)) u_row_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (row_n),
        .q      (row_sync)
    );

    assign sample   = (dwell == DWELL_LAST);
    assign scan_end = sample && (col == 2'd2);
    assign col_next = (col == 2'd2) ? 2'd0 : col + 2'd1;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        snap_next = snapshot;
        for (int r = 0; r < ROWS; r++) begin
            snap_next[r * COLS + int'(col)] = ~row_sync[r];
        end

        stable_next = stable;
        if (snap_next != candidate) begin
            stable_next = SW'(1);
        end else if (stable < STABLE_MAX) begin
            stable_next = stable + SW'(1);
        end

        // Two or more closed keys cannot be told apart from ghosting: release all.
        commit_value = (key_count(snap_next) > 1) ? '0 : snap_next;
        commit       = scan_end && (stable_next == STABLE_MAX);

        keypad_next = '0;
        for (int i = 0; i < KEYS; i++) begin
            for (int d = 0; d < 10; d++) begin
                if (committed[i] && key_to_digit(i) == 4'(d)) begin
                    keypad_next[d] = 1'b1;
                end
            end
        end
    end

    // NOTE: the scan buffers are reset along with the control state so a reset
    // mid-debounce can never leave a stale partial scan to be committed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dwell        <= '0;
            col          <= 2'd0;
            col_n        <= 3'b110;
            snapshot     <= '0;
            candidate    <= '0;
            stable       <= '0;
            committed    <= '0;
            commit_pulse <= 1'b0;
            keypad       <= '0;
            startn       <= 1'b1;
            clearn       <= 1'b1;
            press_strobe <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;

            if (sample) begin
                dwell    <= '0;
                col      <= col_next;
                col_n    <= ~(3'b001 << col_next);
                snapshot <= snap_next;
            end else begin
                dwell <= dwell + DW'(1);
            end

            if (scan_end) begin
                candidate <= snap_next;
                stable    <= stable_next;
                if (commit) begin
                    committed    <= commit_value;
                    commit_pulse <= (commit_value != committed) &&
                                    (key_count(commit_value) == 1);
                end
            end

            keypad       <= keypad_next;
            startn       <= ~committed[KEY_HASH];
            clearn       <= ~committed[KEY_STAR];
            press_strobe <= commit_pulse;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: models the key matrix from col_n and
// checks commit latency, decode, strobes, ghost handling and reset.
module tb_keypad_scanner;

    logic        clk;
    logic        resetn;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic [9:0]  keypad;
    logic        startn;
    logic        clearn;
    logic        press_strobe;
    logic [11:0] held;

    int checks;
    int failures;
    int strobes;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .row_n        (row_n),
        .col_n        (col_n),
        .keypad       (keypad),
        .startn       (startn),
        .clearn       (clearn),
        .press_strobe (press_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (held[r * 3 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (press_strobe) strobes++;
    endtask

    task automatic wait_scan_end();
        logic [2:0] prev;
        for (int i = 0; i < 40; i++) begin
            prev = col_n;
            step();
            if (prev == 3'b011 && col_n == 3'b110) return;
        end
        checks++;
        failures++;
        $display("FAIL scan_wrap: col_n=%b never wrapped 011->110", col_n);
    endtask

    task automatic wait_out(input logic [9:0] kp, input logic sn, input logic cn,
                            input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (keypad === kp && startn === sn && clearn === cn) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic settle();
        held = '0;
        repeat (60) step();
        strobes = 0;
    endtask

    task automatic test_reset();
        held   = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({col_n, keypad, startn, clearn, press_strobe} !== {3'b110, 10'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got col_n=%b keypad=%b startn=%b clearn=%b strobe=%b",
                     col_n, keypad, startn, clearn, press_strobe);
        end
        @(negedge clk);
        resetn  = 1'b1;
        strobes = 0;
    endtask

    task automatic test_idle_scan();
        logic [2:0] exp_col;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_col = ~(3'b001 << ((k / 4) % 3));
            checks++;
            if (col_n !== exp_col) begin
                failures++;
                $display("FAIL idle_col k=%0d: got %b want %b", k, col_n, exp_col);
            end
        end
        repeat (36) step();
        checks++;
        if (keypad !== 10'd0 || startn !== 1'b1 || clearn !== 1'b1 || strobes != 0) begin
            failures++;
            $display("FAIL idle_outputs: keypad=%b startn=%b clearn=%b strobes=%0d want 0,1,1,0",
                     keypad, startn, clearn, strobes);
        end
    endtask

    task automatic test_digit5();
        int cyc;
        settle();
        wait_scan_end();
        strobes = 0;
        held[4] = 1'b1;
        wait_out(10'b0000100000, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL digit5_press_latency: got %0d cycles want 36..51", cyc);
        end
        repeat (3) step();
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL digit5_strobe: got %0d strobes want 1", strobes);
        end
        wait_scan_end();
        strobes = 0;
        held    = '0;
        wait_out(10'd0, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL digit5_release_latency: got %0d cycles want 36..51", cyc);
        end
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL digit5_release_strobe: got %0d strobes want 0", strobes);
        end
    endtask

    task automatic test_bounce();
        logic [19:0] pattern;
        int cyc;
        pattern = 20'b0000000100011010_0111;
        settle();
        wait_scan_end();
        for (int i = 0; i < 20; i++) begin
            held[6] = pattern[i];
            step();
        end
        held[6] = 1'b1;
        wait_out(10'b0010000000, 1'b1, 1'b1, 80, cyc);
        checks++;
        if (cyc < 36) begin
            failures++;
            $display("FAIL bounce_latency: got %0d cycles after last bounce want >=36", cyc);
        end
        repeat (3) step();
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL bounce_strobe: got %0d strobes want 1", strobes);
        end
    endtask

    task automatic test_hash_star();
        int cyc;
        settle();
        wait_scan_end();
        held[11] = 1'b1;
        wait_out(10'd0, 1'b0, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL hash_start: got %0d cycles (startn=%b keypad=%b) want 36..51",
                     cyc, startn, keypad);
        end
        held[9] = 1'b1;
        wait_out(10'd0, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 0) begin
            failures++;
            $display("FAIL ghost_release: startn=%b clearn=%b keypad=%b want 1,1,0",
                     startn, clearn, keypad);
        end
        repeat (3) step();
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL hash_star_strobes: got %0d want 1", strobes);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        settle();
        wait_scan_end();
        held[2] = 1'b1;
        wait_out(10'b0000001000, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL digit3_latency: got %0d cycles want 36..51", cyc);
        end
        wait_scan_end();
        held = 12'b0000_1000_0000;
        wait_out(10'b0100000000, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL digit8_latency: got %0d cycles want 36..51", cyc);
        end
        repeat (3) step();
        checks++;
        if (strobes != 2) begin
            failures++;
            $display("FAIL switch_strobes: got %0d want 2", strobes);
        end
        held = 12'b0100_0000_0010;
        wait_out(10'd0, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 0 || strobes != 2) begin
            failures++;
            $display("FAIL two_digit_ghost: keypad=%b strobes=%0d want 0 and 2", keypad, strobes);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        settle();
        wait_scan_end();
        held[0] = 1'b1;
        repeat (20) step();
        resetn = 1'b0;
        #1;
        checks++;
        if ({col_n, keypad, startn, clearn, press_strobe} !== {3'b110, 10'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_outputs: got col_n=%b keypad=%b startn=%b clearn=%b strobe=%b",
                     col_n, keypad, startn, clearn, press_strobe);
        end
        @(negedge clk);
        resetn  = 1'b1;
        strobes = 0;
        wait_out(10'b0000000010, 1'b1, 1'b1, 60, cyc);
        checks++;
        if (cyc < 36 || cyc > 51) begin
            failures++;
            $display("FAIL mid_reset_recommit: got %0d cycles want 36..51", cyc);
        end
        repeat (3) step();
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL mid_reset_strobe: got %0d want 1", strobes);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        strobes  = 0;
        held     = '0;
        resetn   = 1'b0;
        test_reset();
        test_idle_scan();
        test_digit5();
        test_bounce();
        test_hash_star();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
